// File: rtl/exec_arith_pkg.sv
// Shared types and widths for the execute-stage arithmetic block.
package exec_arith_pkg;

   localparam int WORD_W = 64;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

endpackage

// File: rtl/adder_w.sv
// WIDTH-bit ripple-agnostic adder with carry-in and carry-out.
module adder_w
   import exec_arith_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] total;

   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   end

   assign sum  = total[WIDTH-1:0];
   assign cout = total[WIDTH];

endmodule

// File: rtl/exec_arith_unit.sv
// Execute ALU plus the shared PC adder, with a registered ALU copy.
module exec_arith_unit
   import exec_arith_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [SEL_W-1:0] ALU_Sel,
   output logic [WIDTH-1:0] ALU_Out,
   output logic             zero,
   output logic [WIDTH-1:0] alu_q,
   output logic             zero_q,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             carry
);

   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] arith;
   logic             unused_cout;

   // SUB reuses the adder: A + ~B + 1
   assign is_sub = (ALU_Sel == ALU_SUB);
   assign b_eff  = is_sub ? ~B : B;

   adder_w #(.WIDTH(WIDTH)) u_alu_add (
      .a    (A),
      .b    (b_eff),
      .cin  (is_sub),
      .sum  (arith),
      .cout (unused_cout)
   );

   adder_w #(.WIDTH(WIDTH)) u_pc_add (
      .a    (a),
      .b    (b),
      .cin  (1'b0),
      .sum  (out),
      .cout (carry)
   );

   always_comb begin
      ALU_Out = '0;
      case (ALU_Sel)
         ALU_ADD: ALU_Out = arith;
         ALU_SUB: ALU_Out = arith;
         ALU_AND: ALU_Out = A & B;
         ALU_OR:  ALU_Out = A | B;
         default: ALU_Out = '0;
      endcase
   end

   assign zero = (ALU_Out == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         alu_q  <= ALU_Out;
         zero_q <= zero;
      end
   end

endmodule

// File: tb/tb_exec_arith_unit.sv
// Directed self-checking bench for exec_arith_unit.
module tb_exec_arith_unit;

   localparam int W = 64;
   localparam logic [W-1:0] ONES = {W{1'b1}};

   logic         clk;
   logic         rst;
   logic [W-1:0] A, B, a, b;
   logic [1:0]   ALU_Sel;
   logic [W-1:0] ALU_Out, alu_q, out;
   logic         zero, zero_q, carry;

   int checks = 0;
   int errors = 0;

   exec_arith_unit #(.WIDTH(W), .SEL_W(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .A       (A),
      .B       (B),
      .ALU_Sel (ALU_Sel),
      .ALU_Out (ALU_Out),
      .zero    (zero),
      .alu_q   (alu_q),
      .zero_q  (zero_q),
      .a       (a),
      .b       (b),
      .out     (out),
      .carry   (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs,
                        input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      A = '0; B = '0; ALU_Sel = 2'b00;
      a = 64'h100; b = 64'h4;
      #1;
      check("rst_alu_q", alu_q, '0);
      check("rst_zero_q", 64'(zero_q), 64'd1);
      check("rst_add_out", out, 64'h104);
      check("rst_add_carry", 64'(carry), 64'd0);

      // ADD
      @(negedge clk);
      rst = 1'b0;
      A = 64'd5; B = 64'd7; ALU_Sel = 2'b00;
      #1;
      check("add_out", ALU_Out, 64'd12);
      check("add_zero", 64'(zero), 64'd0);
      check("add_q_before_edge", alu_q, '0);
      @(posedge clk); #1;
      check("add_q", alu_q, 64'd12);
      check("add_zero_q", 64'(zero_q), 64'd0);

      // SUB equal
      @(negedge clk);
      A = 64'h1234; B = 64'h1234; ALU_Sel = 2'b01;
      #1;
      check("sub_eq_out", ALU_Out, '0);
      check("sub_eq_zero", 64'(zero), 64'd1);
      @(posedge clk); #1;
      check("sub_eq_q", alu_q, '0);
      check("sub_eq_zero_q", 64'(zero_q), 64'd1);

      // SUB borrow
      @(negedge clk);
      A = '0; B = 64'd1; ALU_Sel = 2'b01;
      #1;
      check("sub_borrow_out", ALU_Out, ONES);
      check("sub_borrow_zero", 64'(zero), 64'd0);

      // ADD wrap
      @(negedge clk);
      A = ONES; B = 64'd1; ALU_Sel = 2'b00;
      #1;
      check("add_wrap_out", ALU_Out, '0);
      check("add_wrap_zero", 64'(zero), 64'd1);

      // SUB ordinary
      @(negedge clk);
      A = 64'd100; B = 64'd58; ALU_Sel = 2'b01;
      #1;
      check("sub_out", ALU_Out, 64'd42);

      // Logic ops
      @(negedge clk);
      A = 64'hF0F0; B = 64'h0FF0; ALU_Sel = 2'b10;
      #1;
      check("and_out", ALU_Out, 64'h00F0);
      ALU_Sel = 2'b11;
      #1;
      check("or_out", ALU_Out, 64'hFFF0);
      @(posedge clk); #1;
      check("or_q", alu_q, 64'hFFF0);

      // Standalone adder
      @(negedge clk);
      a = 64'h100; b = 64'd4;
      #1;
      check("pc_add_out", out, 64'h104);
      check("pc_add_carry", 64'(carry), 64'd0);
      a = ONES; b = 64'd4;
      #1;
      check("pc_wrap_out", out, 64'd3);
      check("pc_wrap_carry", 64'(carry), 64'd1);
      a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0001;
      #1;
      check("pc_msb_out", out, 64'd1);
      check("pc_msb_carry", 64'(carry), 64'd1);

      // Async reset mid-cycle
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_q", alu_q, '0);
      check("async_rst_zero_q", 64'(zero_q), 64'd1);
      check("rst_comb_tracks", ALU_Out, 64'hFFF0);
      @(posedge clk); #1;
      check("rst_hold1_q", alu_q, '0);
      @(posedge clk); #1;
      check("rst_hold2_q", alu_q, '0);
      check("rst_hold2_zero_q", 64'(zero_q), 64'd1);

      // Release: next edge captures current ALU_Out
      @(negedge clk);
      rst = 1'b0;
      A = 64'd5; B = 64'd7; ALU_Sel = 2'b00;
      #1;
      check("release_q_pre", alu_q, '0);
      @(posedge clk); #1;
      check("release_q", alu_q, 64'd12);
      check("release_zero_q", 64'(zero_q), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
